// File: rtl/alarma_pkg.sv
// Shared state codes, memoria bit indices and default timing for the animal-alarm controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alarma_pkg;

  typedef enum logic [2:0] {
    DESARMADO = 3'd0,
    SALIDA    = 3'd1,
    ARMADO    = 3'd2,
    ENTRADA   = 3'd3,
    ALARMA    = 3'd4
  } estado_t;

  localparam int MEM_MT = 0;
  localparam int MEM_TB = 1;

  localparam int DELAY_SALIDA_DEF  = 8;
  localparam int DELAY_ENTRADA_DEF = 8;
  localparam int T_SIRENA_DEF      = 16;
  localparam int CNT_W_DEF         = 8;

  // A duration must fit the counter: 1..2^w cycles means a terminal count of 0..2^w-1.
  function automatic logic duracion_ok(input int valor, input int w);
    return (w >= 1) && (w < 31) && (valor >= 1) && (valor <= (1 << w));
  endfunction

endpackage

// File: rtl/alarma_contador.sv
// Shared delay counter: counts up while enabled and flags when it reaches a runtime limit.
// Latency: fin is combinational from the count register; clear/increment take effect next edge.
// Backpressure: none; holds at the limit instead of wrapping.
module alarma_contador #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limite,
  output logic             fin
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && !fin) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign fin = (cnt == limite);

endmodule

// File: rtl/alarma_animal_ctrl.sv
// Armed/disarmed sequencer with exit delay, entry delay and timed siren; ALARMA_MEMORIA_EN adds the trigger-cause latch.
// Latency: Moore outputs, 1 cycle from sampled input to output.
// Backpressure: none; inputs are level-sampled every edge.
module alarma_animal_ctrl
  import alarma_pkg::*;
#(
  parameter int DELAY_SALIDA  = DELAY_SALIDA_DEF,
  parameter int DELAY_ENTRADA = DELAY_ENTRADA_DEF,
  parameter int T_SIRENA      = T_SIRENA_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       armar,
  input  logic       desarmar,
  input  logic       m,
  input  logic       ta,
  input  logic       tb,
  output logic       alarma,
  output logic       aviso,
  output logic       armado,
  output logic [2:0] estado,
  output logic [1:0] memoria
);

  if (!(duracion_ok(DELAY_SALIDA, CNT_W) && duracion_ok(DELAY_ENTRADA, CNT_W) &&
        duracion_ok(T_SIRENA, CNT_W))) begin : g_param_invalido
    $fatal(1, "alarma_animal_ctrl: delays must lie in 1..2^CNT_W");
  end

  localparam logic [CNT_W-1:0] LIM_SALIDA  = CNT_W'(DELAY_SALIDA - 1);
  localparam logic [CNT_W-1:0] LIM_ENTRADA = CNT_W'(DELAY_ENTRADA - 1);
  localparam logic [CNT_W-1:0] LIM_SIRENA  = CNT_W'(T_SIRENA - 1);

  estado_t          state_q;
  estado_t          state_d;
  logic             disparo_tb;
  logic             cnt_clr;
  logic             cnt_en;
  logic             cnt_fin;
  logic [CNT_W-1:0] cnt_limite;

  // desarmar outranks tb, so a panic trigger only counts when no disarm is present.
  assign disparo_tb = tb && !desarmar;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DESARMADO;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (desarmar) begin
      state_d = DESARMADO;
    end else if (tb) begin
      state_d = ALARMA;
    end else begin
      case (state_q)
        DESARMADO: if (armar)   state_d = SALIDA;
        SALIDA:    if (cnt_fin) state_d = ARMADO;
        ARMADO:    if (m && ta) state_d = ENTRADA;
        ENTRADA:   if (cnt_fin) state_d = ALARMA;
        ALARMA:    if (cnt_fin) state_d = ARMADO;
        default:                state_d = DESARMADO;
      endcase
    end
  end

  always_comb begin
    cnt_limite = '0;
    cnt_en     = 1'b0;
    case (state_q)
      SALIDA: begin
        cnt_limite = LIM_SALIDA;
        cnt_en     = 1'b1;
      end
      ENTRADA: begin
        cnt_limite = LIM_ENTRADA;
        cnt_en     = 1'b1;
      end
      ALARMA: begin
        cnt_limite = LIM_SIRENA;
        cnt_en     = 1'b1;
      end
      default: ;
    endcase
  end

  // Any state change restarts timing; tb while already sounding restarts the siren too.
  assign cnt_clr = (state_d != state_q) || disparo_tb;

  alarma_contador #(
    .CNT_W (CNT_W)
  ) u_contador (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .limite (cnt_limite),
    .fin    (cnt_fin)
  );

  assign alarma = (state_q == ALARMA);
  assign aviso  = (state_q == SALIDA) || (state_q == ENTRADA);
  assign armado = (state_q == ARMADO) || (state_q == ENTRADA) || (state_q == ALARMA);
  assign estado = state_q;

`ifdef ALARMA_MEMORIA_EN
  logic [1:0] memoria_q;
  logic [1:0] memoria_set;
  logic       memoria_clr;

  // ENTRADA is only reachable from ARMADO through m&ta, so entering it identifies that cause.
  always_comb begin
    memoria_set         = 2'b00;
    memoria_set[MEM_MT] = (state_q == ARMADO) && (state_d == ENTRADA);
    memoria_set[MEM_TB] = disparo_tb;
  end

  assign memoria_clr = (state_q != SALIDA) && (state_d == SALIDA);

  always_ff @(posedge clk) begin
    if (rst || memoria_clr) begin
      memoria_q <= 2'b00;
    end else begin
      memoria_q <= memoria_q | memoria_set;
    end
  end

  assign memoria = memoria_q;
`else
  assign memoria = 2'b00;
`endif

endmodule

// File: doc/alarma_animal_ctrl.md
# alarma_animal_ctrl

Sequencing controller for the animal-alarm datapath: it wraps the sensor logic (motion `m` qualified by contact `ta`, and the direct trigger `tb`) in an armed/disarmed state machine with exit delay, entry delay and timed siren. It sits between the user controls (arm/disarm buttons) and the siren/indicator outputs, and replaces the raw combinational alarm equation at the top level.

## Interface
- `DELAY_SALIDA`, default 8: exit-delay length in clock cycles, valid range 1..2^CNT_W.
- `DELAY_ENTRADA`, default 8: entry-delay length in clock cycles, valid range 1..2^CNT_W.
- `T_SIRENA`, default 16: siren-on length in clock cycles, valid range 1..2^CNT_W.
- `CNT_W`, default 8: width of the shared delay counter.
- `clk`  in  1: system clock. All logic is rising-edge.
- `rst`  in  1: reset. It is synchronous and active-high.
- `armar`  in  1: arm request, level-sampled.
- `desarmar`  in  1: disarm request, level-sampled.
- `m`  in  1: motion sensor.
- `ta`  in  1: contact sensor A. It qualifies `m`.
- `tb`  in  1: direct trigger (tamper/panic).
- `alarma`  out  1: siren drive.
- `aviso`  out  1: beeper during exit and entry delays.
- `armado`  out  1: armed indicator.
- `estado`  out  3: current state code.
- `memoria`  out  2: latched trigger cause. Bit 0 is the `m&ta` path and bit 1 is the `tb` path.

## Operation
- The state machine has five states: DESARMADO=0, SALIDA=1, ARMADO=2, ENTRADA=3, ALARMA=4. Codes 5–7 go to DESARMADO on the next edge.
- Evaluation priority each edge, highest first:
  1. `rst`
  2. `desarmar`
  3. `tb`
  4. state-specific conditions
- `desarmar=1` goes to DESARMADO from any state.
- `tb=1` (without `desarmar`) goes to ALARMA from any state, including DESARMADO. It clears the counter, which restarts the siren if already in ALARMA.
- DESARMADO: `armar=1` goes to SALIDA and the counter is cleared.
- SALIDA: the counter increments each cycle. At count == DELAY_SALIDA-1 the next state is ARMADO. `m`/`ta` are ignored.
- ARMADO: `m&ta`=1 goes to ENTRADA and the counter is cleared.
- ENTRADA: the counter increments. At count == DELAY_ENTRADA-1 the next state is ALARMA and the counter is cleared. `armar` is ignored.
- ALARMA: the counter increments. At count == T_SIRENA-1 the next state is ARMADO (automatic re-arm). Sensor activity is ignored apart from `tb` restarting the siren.
- `armar` is ignored outside DESARMADO. `armar` and `desarmar` high together resolves to DESARMADO.
- Counter arithmetic is unsigned CNT_W-bit and is cleared on every state change. Terminal compares prevent wrap-around. Parameter values of 0 or above 2^CNT_W are a fatal elaboration error.
- Outputs are Moore, decoded from the state register:
  - `alarma` = (state==ALARMA)
  - `aviso` = SALIDA|ENTRADA
  - `armado` = ARMADO|ENTRADA|ALARMA
  - `estado` = the state code

## Timing
- Reset values: state DESARMADO, counter 0, `alarma`=0, `aviso`=0, `armado`=0, `estado`=0, `memoria`=0.
- Input to output latency is 1 cycle. A condition sampled at edge k is visible on the outputs after edge k.
- Exit, entry and siren durations are exactly DELAY_SALIDA, DELAY_ENTRADA and T_SIRENA cycles of the respective state.
- Reset mid-operation (any state, any count) returns to reset values on that edge.
- Inputs are assumed already synchronous to `clk`; the block adds no synchronizers.

## Configuration
- `ALARMA_MEMORIA_EN` defined:
  - `memoria[0]` sets on the ENTRADA entry caused by `m&ta`.
  - `memoria[1]` sets on any `tb`-caused transition to ALARMA.
  - Both bits are sticky through ALARMA and re-arm. They clear only on `rst` or on the transition into SALIDA, so they survive disarm for inspection.
- `ALARMA_MEMORIA_EN` undefined: `memoria` is tied to 2'b00 and no flops are generated.

## Structure
- Package `alarma_pkg` holds:
  - the state enum/localparam codes (3-bit)
  - the `memoria` bit index constants
  - the default delay constants
- Sub-module `alarma_contador`: CNT_W-bit counter with clear, enable and a terminal-count flag against a runtime limit. The FSM instantiates it once and muxes the limit by state.

## Test plan
- Arm flow: `rst` 2 cycles, pulse `armar` 1 cycle → `aviso`=1 for exactly 8 cycles, then `armado`=1, `estado`=2.
- Entry delay: armed, `m=1,ta=1` for 1 cycle → `estado`=3 for 8 cycles, then `alarma`=1 for 16 cycles, then `estado`=2 and `alarma`=0.
- Qualification: armed, `m=1,ta=0` for 20 cycles → stays `estado`=2 and `alarma`=0. Then `desarmar` mid-ENTRADA → `estado`=0 next cycle and `alarma` never asserts.
- Direct trigger: `tb=1` for 1 cycle while DESARMADO → `alarma`=1 the next cycle. `tb` again at siren count 10 → siren lasts 16 cycles from the second pulse.
- Priority/reset: `desarmar`, `tb` and `armar` asserted together in ALARMA → `estado`=0. `rst` during ENTRADA count 5 → all outputs 0 next cycle.
- `ALARMA_MEMORIA_EN`: an `m&ta` trigger then a `tb` trigger → `memoria`=2'b11 held after `desarmar`, cleared to 2'b00 on the next `armar`. With the macro undefined, `memoria` stays 0 throughout.
